// File: rtl/avm_uart_slave.sv
// avm_uart_slave: Avalon-MM slave UART, 8N1, LSB first.
// Register map: 0x00 RX data (read pops), 0x04 TX data (write loads),
// 0x08 STATUS (read) / error clear (write).
// STATUS byte: {RRDY, TRDY, 0, TOE, ROE, FE, 0, 0}.
// Bus handshake uses one fixed wait state. Request, address and data are
// captured on the wait edge, and side effects are applied in the ack cycle.
// Build macro UART_RX_FIFO_EN replaces the single RX holding register with a
// 4-entry RX FIFO. In that mode, overrun drops the new byte.
module avm_uart_slave #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic        avm_clk,
    input  logic        avm_rst_n,
    input  logic [4:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        avs_waitrequest,
    input  logic        uart_rxd,
    output logic        uart_txd
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
    localparam logic [CW-1:0] BAUD_ZERO = CW'(0);

    localparam logic [4:0] ADDR_RX     = 5'h00;
    localparam logic [4:0] ADDR_TX     = 5'h04;
    localparam logic [4:0] ADDR_STATUS = 5'h08;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // ------------------------------------------------------------------
    // Bus side
    // ------------------------------------------------------------------
    logic        ack_r;
    logic        cmd_rd_r;
    logic        cmd_wr_r;
    logic [4:0]  addr_r;
    logic [7:0]  wdata_r;
    logic [31:0] rd_mux_s;
    logic [7:0]  status_s;
    logic        rd_pop_s;
    logic        tx_load_s;
    logic        toe_set_s;
    logic        err_clr_s;
    logic        unused_wdata_s;

    // Error flags.
    logic        toe_r;
    logic        roe_r;
    logic        fe_r;
    logic        roe_set_s;
    logic        fe_set_s;

    // RX datapath.
    logic        rxd_meta_r;
    logic        rxd_sync_r;
    logic        rxd_prev_r;
    rx_state_t   rx_state_r;
    logic [CW-1:0] rx_cnt_r;
    logic [2:0]  rx_bit_r;
    logic [7:0]  rx_shift_r;
    logic        rx_done_s;
    logic        rx_ferr_s;
    logic        rrdy_s;
    logic [7:0]  rx_head_s;

    // TX datapath.
    tx_state_t   tx_state_r;
    logic [CW-1:0] tx_cnt_r;
    logic [2:0]  tx_bit_r;
    logic [7:0]  tx_shift_r;
    logic [7:0]  tx_hold_r;
    logic        tx_full_r;
    logic        tx_take_s;

    // Only the low data byte carries information.
    assign unused_wdata_s  = ^avs_writedata[31:8];
    assign avs_waitrequest = (avs_read | avs_write) & ~ack_r;

    // Decode the ack-cycle side effects from the captured request.
    always_comb begin
        rd_pop_s  = 1'b0;
        tx_load_s = 1'b0;
        toe_set_s = 1'b0;
        err_clr_s = 1'b0;
        if (ack_r) begin
            rd_pop_s  = cmd_rd_r & (addr_r == ADDR_RX);
            tx_load_s = cmd_wr_r & (addr_r == ADDR_TX) & ~tx_full_r;
            toe_set_s = cmd_wr_r & (addr_r == ADDR_TX) & tx_full_r;
            err_clr_s = cmd_wr_r & (addr_r == ADDR_STATUS);
        end else begin
            rd_pop_s  = 1'b0;
            tx_load_s = 1'b0;
            toe_set_s = 1'b0;
            err_clr_s = 1'b0;
        end
    end

    // Build the read-data value for the address currently on the bus.
    always_comb begin
        status_s = {rrdy_s, ~tx_full_r, 1'b0, toe_r, roe_r, fe_r, 2'b00};
        rd_mux_s = 32'h0000_0000;
        case (avs_address)
            ADDR_RX:     rd_mux_s = {24'h00_0000, rx_head_s};
            ADDR_STATUS: rd_mux_s = {24'h00_0000, status_s};
            default:     rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Handshake: ack one cycle after a stalled request, capture request and read data.
    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            ack_r        <= 1'b0;
            cmd_rd_r     <= 1'b0;
            cmd_wr_r     <= 1'b0;
            addr_r       <= 5'h00;
            wdata_r      <= 8'h00;
            avs_readdata <= 32'h0000_0000;
        end else if (avs_waitrequest) begin
            ack_r        <= 1'b1;
            cmd_rd_r     <= avs_read;
            cmd_wr_r     <= avs_write;
            addr_r       <= avs_address;
            wdata_r      <= avs_writedata[7:0];
            avs_readdata <= avs_read ? rd_mux_s : 32'h0000_0000;
        end else begin
            ack_r        <= 1'b0;
            cmd_rd_r     <= 1'b0;
            cmd_wr_r     <= 1'b0;
            addr_r       <= addr_r;
            wdata_r      <= wdata_r;
            avs_readdata <= 32'h0000_0000;
        end
    end

    // Sticky error flags: a new error wins over a clear in the same cycle.
    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            toe_r <= 1'b0;
            roe_r <= 1'b0;
            fe_r  <= 1'b0;
        end else begin
            toe_r <= toe_set_s | (toe_r & ~err_clr_s);
            roe_r <= roe_set_s | (roe_r & ~err_clr_s);
            fe_r  <= fe_set_s  | (fe_r  & ~err_clr_s);
        end
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
        end else begin
            rxd_meta_r <= uart_rxd;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
        end
    end

    assign rx_done_s = (rx_state_r == RX_STOP) & (rx_cnt_r == BAUD_LAST) & rxd_sync_r;
    assign rx_ferr_s = (rx_state_r == RX_STOP) & (rx_cnt_r == BAUD_LAST) & ~rxd_sync_r;
    assign fe_set_s  = rx_ferr_s;

    // Receiver FSM: validate start at mid-bit, then sample 8 data bits and the stop bit.
    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= BAUD_ZERO;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= BAUD_ZERO;
                    rx_bit_r <= 3'd0;
                    if (rxd_prev_r & ~rxd_sync_r) begin
                        rx_state_r <= RX_START;
                    end else begin
                        rx_state_r <= RX_IDLE;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r == HALF_LAST) begin
                        rx_cnt_r   <= BAUD_ZERO;
                        rx_state_r <= rxd_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + BAUD_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == BAUD_LAST) begin
                        rx_cnt_r   <= BAUD_ZERO;
                        rx_shift_r <= {rxd_sync_r, rx_shift_r[7:1]};
                        rx_bit_r   <= rx_bit_r + 3'd1;
                        if (rx_bit_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            rx_state_r <= RX_DATA;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + BAUD_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == BAUD_LAST) begin
                        rx_cnt_r   <= BAUD_ZERO;
                        rx_state_r <= RX_IDLE;
                    end else begin
                        rx_cnt_r <= rx_cnt_r + BAUD_ONE;
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                    rx_cnt_r   <= BAUD_ZERO;
                    rx_bit_r   <= 3'd0;
                end
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    logic [7:0] rx_mem_r [0:3];
    logic [1:0] rx_wr_ptr_r;
    logic [1:0] rx_rd_ptr_r;
    logic [2:0] rx_count_r;
    logic       rx_push_s;
    logic       rx_pop_s;

    assign rx_push_s = rx_done_s & (rx_count_r != 3'd4);
    assign rx_pop_s  = rd_pop_s & (rx_count_r != 3'd0);
    assign roe_set_s = rx_done_s & (rx_count_r == 3'd4);
    assign rrdy_s    = (rx_count_r != 3'd0);
    assign rx_head_s = rx_mem_r[rx_rd_ptr_r];

    // RX FIFO: push completed bytes, pop on data-register read, drop when full.
    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                rx_mem_r[i] <= 8'h00;
            end
            rx_wr_ptr_r <= 2'd0;
            rx_rd_ptr_r <= 2'd0;
            rx_count_r  <= 3'd0;
        end else begin
            if (rx_push_s) begin
                rx_mem_r[rx_wr_ptr_r] <= rx_shift_r;
                rx_wr_ptr_r           <= rx_wr_ptr_r + 2'd1;
            end
            if (rx_pop_s) begin
                rx_rd_ptr_r <= rx_rd_ptr_r + 2'd1;
            end
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + 3'd1;
                2'b01:   rx_count_r <= rx_count_r - 3'd1;
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end
`else
    logic [7:0] rx_data_r;
    logic       rx_valid_r;

    assign roe_set_s = rx_done_s & rx_valid_r & ~rd_pop_s;
    assign rrdy_s    = rx_valid_r;
    assign rx_head_s = rx_data_r;

    // Single holding register: a new byte overwrites, and a read clears valid.
    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
        end else if (rx_done_s) begin
            rx_data_r  <= rx_shift_r;
            rx_valid_r <= 1'b1;
        end else if (rd_pop_s) begin
            rx_valid_r <= 1'b0;
        end else begin
            rx_valid_r <= rx_valid_r;
        end
    end
`endif

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    // The shifter takes the holding register when idle, or at the end of a
    // stop bit, so back-to-back frames do not leave an idle gap.
    assign tx_take_s = tx_full_r &
                       ((tx_state_r == TX_IDLE) |
                        ((tx_state_r == TX_STOP) & (tx_cnt_r == BAUD_LAST)));

    // Transmitter: holding register plus start/data/stop frame sequencer.
    always_ff @(posedge avm_clk) begin
        if (!avm_rst_n) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= BAUD_ZERO;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_hold_r  <= 8'h00;
            tx_full_r  <= 1'b0;
            uart_txd   <= 1'b1;
        end else begin
            if (tx_load_s) begin
                tx_hold_r <= wdata_r;
                tx_full_r <= 1'b1;
            end else if (tx_take_s) begin
                tx_full_r <= 1'b0;
            end else begin
                tx_full_r <= tx_full_r;
            end

            case (tx_state_r)
                TX_IDLE: begin
                    tx_cnt_r <= BAUD_ZERO;
                    tx_bit_r <= 3'd0;
                    if (tx_take_s) begin
                        tx_shift_r <= tx_hold_r;
                        uart_txd   <= 1'b0;
                        tx_state_r <= TX_START;
                    end else begin
                        uart_txd   <= 1'b1;
                        tx_state_r <= TX_IDLE;
                    end
                end
                TX_START: begin
                    if (tx_cnt_r == BAUD_LAST) begin
                        tx_cnt_r   <= BAUD_ZERO;
                        tx_bit_r   <= 3'd0;
                        uart_txd   <= tx_shift_r[0];
                        tx_state_r <= TX_DATA;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + BAUD_ONE;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_r == BAUD_LAST) begin
                        tx_cnt_r <= BAUD_ZERO;
                        if (tx_bit_r == 3'd7) begin
                            tx_bit_r   <= 3'd0;
                            uart_txd   <= 1'b1;
                            tx_state_r <= TX_STOP;
                        end else begin
                            tx_bit_r   <= tx_bit_r + 3'd1;
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                            uart_txd   <= tx_shift_r[1];
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + BAUD_ONE;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_r == BAUD_LAST) begin
                        tx_cnt_r <= BAUD_ZERO;
                        if (tx_take_s) begin
                            tx_shift_r <= tx_hold_r;
                            uart_txd   <= 1'b0;
                            tx_state_r <= TX_START;
                        end else begin
                            uart_txd   <= 1'b1;
                            tx_state_r <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + BAUD_ONE;
                    end
                end
                default: begin
                    tx_state_r <= TX_IDLE;
                    tx_cnt_r   <= BAUD_ZERO;
                    uart_txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avm_uart_slave.sv
// Testbench for avm_uart_slave (CLK_HZ=1 MHz, BAUD=100 kHz, DIV=10).
// Vector table plus hand sequences plus randomized RX traffic checked
// against a queue-based model. Honors UART_RX_FIFO_EN like the design.
`timescale 1ns/1ps
module tb_avm_uart_slave;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
    localparam int DIV    = CLK_HZ / BAUD;

    logic        avm_clk = 1'b0;
    logic        avm_rst_n;
    logic [4:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_waitrequest;
    logic        uart_rxd;
    logic        uart_txd;

    int n_tests = 0;
    int n_fail  = 0;

    avm_uart_slave #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .avm_clk         (avm_clk),
        .avm_rst_n       (avm_rst_n),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_readdata    (avs_readdata),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_waitrequest (avs_waitrequest),
        .uart_rxd        (uart_rxd),
        .uart_txd        (uart_txd)
    );

    always #5 avm_clk = ~avm_clk;

    // Reference model of the receive side and the error flags.
    logic [7:0] m_q[$];
    logic       m_roe;
    logic       m_fe;

    function automatic void m_rx_byte(input logic [7:0] b);
`ifdef UART_RX_FIFO_EN
        if (m_q.size() == 4) m_roe = 1'b1;
        else m_q.push_back(b);
`else
        if (m_q.size() != 0) begin
            m_roe = 1'b1;
            m_q.delete();
        end
        m_q.push_back(b);
`endif
    endfunction

    function automatic logic [31:0] m_status();
        logic rrdy;
        rrdy = (m_q.size() != 0);
        return {24'h0, rrdy, 1'b1, 1'b0, 1'b0, m_roe, m_fe, 2'b00};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One Avalon transfer; returns read data and the number of stall cycles.
    task automatic bus_xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output int waits);
        @(negedge avm_clk);
        avs_address   = addr;
        avs_writedata = wd;
        avs_read      = ~wr;
        avs_write     = wr;
        #1;
        waits = 0;
        while (avs_waitrequest && waits < 16) begin
            waits++;
            @(negedge avm_clk);
        end
        rd = avs_readdata;
        @(posedge avm_clk);
        #1;
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic rd_chk(input logic [4:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] rd;
        int w;
        bus_xfer(1'b0, addr, 32'h0, rd, w);
        check(name, rd, exp);
        check({name, "_wait"}, w, 1);
    endtask

    task automatic wr_do(input logic [4:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        int w;
        bus_xfer(1'b1, addr, wd, rd, w);
        check("write_wait", w, 1);
    endtask

    // Drive one 8N1 frame on uart_rxd, then idle high for two bit times.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge avm_clk);
            uart_rxd = fr[i];
            repeat (DIV - 1) @(negedge avm_clk);
        end
        @(negedge avm_clk);
        uart_rxd = 1'b1;
        repeat (2 * DIV) @(negedge avm_clk);
    endtask

    // Call right after the TX write completes. Checks start latency and every cycle of each bit.
    task automatic check_tx_frame(input logic [7:0] b, input string name);
        logic [9:0] fr;
        int n;
        logic ok;
        fr = {1'b1, b, 1'b0};
        n = 0;
        @(negedge avm_clk);
        while (uart_txd && n < 40) begin
            n++;
            @(negedge avm_clk);
        end
        check($sformatf("%s_start_latency", name), n, 1);
        for (int i = 0; i < 10; i++) begin
            ok = 1'b1;
            for (int k = 0; k < DIV; k++) begin
                if (uart_txd !== fr[i]) ok = 1'b0;
                @(negedge avm_clk);
            end
            check($sformatf("%s_bit%0d", name, i), ok, 1);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vq[$];

    function automatic void add_vec(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                                    input logic [31:0] exp, input string name);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wd = wd; v.exp = exp; v.name = name;
        vq.push_back(v);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int w;
        int op;
        logic [7:0] b;

        avm_rst_n     = 1'b0;
        avs_address   = 5'h00;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'h0;
        uart_rxd      = 1'b1;
        m_roe = 1'b0;
        m_fe  = 1'b0;

        // Bus-level vector table, applied back-to-back after reset.
        add_vec(1'b0, 5'h08, 32'h0,  32'h40, "stat_reset");
        add_vec(1'b0, 5'h04, 32'h0,  32'h00, "tx_reg_read");
        add_vec(1'b0, 5'h0C, 32'h0,  32'h00, "unmapped_0c");
        add_vec(1'b0, 5'h1F, 32'h0,  32'h00, "unmapped_1f");
        add_vec(1'b0, 5'h00, 32'h0,  32'h00, "rx_reset");
        add_vec(1'b1, 5'h10, 32'hFF, 32'h00, "wr_ignored");
        add_vec(1'b0, 5'h08, 32'h0,  32'h40, "stat_after_ignored");
        add_vec(1'b1, 5'h04, 32'h3A, 32'h00, "wr_tx_3a");
        add_vec(1'b0, 5'h08, 32'h0,  32'h00, "trdy_low_load");
        add_vec(1'b0, 5'h08, 32'h0,  32'h40, "trdy_after_handoff");
        add_vec(1'b1, 5'h04, 32'h11, 32'h00, "wr_tx_11");
        add_vec(1'b1, 5'h04, 32'h22, 32'h00, "wr_tx_22_dropped");
        add_vec(1'b0, 5'h08, 32'h0,  32'h10, "toe_set");
        add_vec(1'b1, 5'h08, 32'h0,  32'h00, "clear_err");
        add_vec(1'b0, 5'h08, 32'h0,  32'h00, "toe_cleared");

        repeat (3) @(negedge avm_clk);
        avm_rst_n = 1'b1;
        check("reset_txd", uart_txd, 1);
        check("reset_readdata", avs_readdata, 32'h0);
        check("reset_waitreq", avs_waitrequest, 0);

        foreach (vq[i]) begin
            bus_xfer(vq[i].wr, vq[i].addr, vq[i].wd, rd, w);
            if (!vq[i].wr) check(vq[i].name, rd, vq[i].exp);
            check({vq[i].name, "_wait"}, w, 1);
        end

        // Let the two queued frames drain.
        repeat (25 * DIV) @(negedge avm_clk);
        rd_chk(5'h08, 32'h40, "stat_tx_drained");

        // Exact TX waveform.
        wr_do(5'h04, 32'hA5);
        check_tx_frame(8'hA5, "tx_a5");

        // Single receive.
        send_frame(8'h3C, 1'b1);
        rd_chk(5'h08, 32'hC0, "rx_3c_status");
        rd_chk(5'h00, 32'h3C, "rx_3c_data");
        rd_chk(5'h08, 32'h40, "rx_3c_popped");

        // Overrun.
`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        rd_chk(5'h08, 32'hC8, "fifo_ovr_status");
        for (int i = 1; i <= 4; i++) rd_chk(5'h00, 32'(i), $sformatf("fifo_rd%0d", i));
        rd_chk(5'h08, 32'h48, "fifo_empty_roe");
`else
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        rd_chk(5'h08, 32'hC8, "ovr_status");
        rd_chk(5'h00, 32'h22, "ovr_data");
        rd_chk(5'h08, 32'h48, "ovr_popped_roe");
`endif
        wr_do(5'h08, 32'h0);
        rd_chk(5'h08, 32'h40, "roe_cleared");

        // Framing error, then clear.
        send_frame(8'h5A, 1'b0);
        rd_chk(5'h08, 32'h44, "fe_status");
        wr_do(5'h08, 32'h0);
        rd_chk(5'h08, 32'h40, "fe_cleared");

        // Short low glitch is rejected without a framing error.
        @(negedge avm_clk);
        uart_rxd = 1'b0;
        repeat (3) @(negedge avm_clk);
        uart_rxd = 1'b1;
        repeat (4 * DIV) @(negedge avm_clk);
        rd_chk(5'h08, 32'h40, "glitch_ignored");

        // Reset in the middle of a TX frame.
        wr_do(5'h04, 32'h77);
        repeat (35) @(negedge avm_clk);
        avm_rst_n = 1'b0;
        @(negedge avm_clk);
        check("midtx_reset_txd", uart_txd, 1);
        check("midtx_reset_readdata", avs_readdata, 32'h0);
        avm_rst_n = 1'b1;
        rd_chk(5'h08, 32'h40, "midtx_reset_status");
        wr_do(5'h04, 32'h55);
        check_tx_frame(8'h55, "tx_55");

        // Randomized RX traffic against the model.
        m_q.delete();
        m_roe = 1'b0;
        m_fe  = 1'b0;
        for (int it = 0; it < 14; it++) begin
            op = $urandom_range(0, 4);
            b  = 8'($urandom);
            case (op)
                0, 1: begin
                    send_frame(b, 1'b1);
                    m_rx_byte(b);
                end
                2: begin
                    send_frame(b, 1'b0);
                    m_fe = 1'b1;
                end
                3: begin
                    if (m_q.size() != 0) begin
                        rd_chk(5'h00, {24'h0, m_q[0]}, $sformatf("rand_rx_data_%0d", it));
                        void'(m_q.pop_front());
                    end
                end
                default: begin
                    wr_do(5'h08, 32'($urandom));
                    m_roe = 1'b0;
                    m_fe  = 1'b0;
                end
            endcase
            rd_chk(5'h08, m_status(), $sformatf("rand_status_%0d", it));
        end

        // Randomized TX bytes.
        for (int it = 0; it < 3; it++) begin
            b = 8'($urandom);
            wr_do(5'h04, {24'h0, b});
            check_tx_frame(b, $sformatf("rand_tx_%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
